pipeline_hazard_controller: RTL and testbench

//  Generates the pipeline control strobes (PC_stall, IF_ID_stall, IF_flush, ID_EX_flush) for the 5-stage core.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_mem_wait_fsm.sv | 55 +++++
 rtl/pipeline_hazard_controller.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, shadow pipe entry, bubble constant.
package hazard_pkg;

    localparam int SHADOW_RD_W = 4;

    typedef enum logic {
        HZ_IDLE     = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                   valid;
        logic [SHADOW_RD_W-1:0] rd;
        logic                   wr_en;
        logic                   is_load;
    } shadow_entry_t;

    localparam shadow_entry_t BUBBLE = '{valid: 1'b0, rd: '0, wr_en: 1'b0, is_load: 1'b0};

    // R0 is hardwired, so a read of R0 never depends on an older write.
    function automatic logic src_match(input logic use_rs,
                                       input logic [SHADOW_RD_W-1:0] rs,
                                       input shadow_entry_t e);
        return use_rs && (rs != '0) && e.valid && e.wr_en && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks multi-cycle data-memory accesses: raises freeze while the access is outstanding and
// latches mem_timeout once the wait count reaches MAX_WAIT (MAX_WAIT must be at least 1).
module hazard_mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic freeze,
    output logic mem_timeout,
    output logic state_dbg
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HZ_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    if (mem_req && !mem_ready) begin
                        state    <= HZ_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= HZ_IDLE;
                    end else begin
                        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_ONE;
                        // Set on the same edge the counter lands on MAX_WAIT.
                        if (wait_cnt >= WAIT_MAX - WAIT_ONE) mem_timeout <= 1'b1;
                    end
                end
                default: state <= HZ_IDLE;
            endcase
        end
    end

    assign freeze    = ((state == HZ_IDLE) && mem_req && !mem_ready) ||
                       ((state == HZ_MEM_WAIT) && !mem_ready);
    assign state_dbg = state;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-side hazard unit: shadow EX/MEM destination tracking, load-use/RAW stall detection,
// memory-wait freeze, mispredict flush, and saturating performance counters.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_W      = SHADOW_RD_W,
    parameter int FORWARDING = 1,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_wr_en,
    input  logic             ID_is_load,
    input  logic             EX_mispredict,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_flush,
    output logic             ID_EX_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The WB slot is not kept: the register file writes before it reads, so WB never matches.
    shadow_entry_t ex_q;
    shadow_entry_t mem_q;

    logic freeze;
    logic ex_match;
    logic mem_match;
    logic data_haz;
    logic take_flush;
    logic take_stall;

    hazard_mem_wait_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_wait (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .mem_timeout (mem_timeout),
        .state_dbg   (dbg_state)
    );

    assign ex_match  = src_match(ID_use_rs1, ID_rs1, ex_q)  || src_match(ID_use_rs2, ID_rs2, ex_q);
    assign mem_match = src_match(ID_use_rs1, ID_rs1, mem_q) || src_match(ID_use_rs2, ID_rs2, mem_q);

    // With forwarding only a load in EX is too late to forward; without it any pending write stalls.
    assign data_haz = ID_valid && ((FORWARDING != 0) ? (ex_match && ex_q.is_load)
                                                     : (ex_match || mem_match));

    always_comb begin
        PC_stall    = 1'b0;
        IF_ID_stall = 1'b0;
        IF_flush    = 1'b0;
        ID_EX_flush = 1'b0;
        take_flush  = 1'b0;
        take_stall  = 1'b0;
        if (!rst) begin
            if (freeze) begin
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
            end else if (EX_mispredict) begin
                IF_flush    = 1'b1;
                ID_EX_flush = 1'b1;
                take_flush  = 1'b1;
            end else if (data_haz) begin
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
                take_stall  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
        end else if (!freeze) begin
            mem_q <= ex_q;
            if (ID_valid && !ID_EX_flush)
                ex_q <= '{valid: 1'b1, rd: ID_rd, wr_en: ID_wr_en, is_load: ID_is_load};
            else
                ex_q <= BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (take_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
            if (take_flush && (flush_count != '1))  flush_count  <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: instance a uses forwarding with 16-bit counters; instance b has no forwarding
// and 2-bit counters so saturation is reachable in a few cycles.
module tb_pipeline_hazard_controller;

    logic       clk;
    logic       rst;
    logic       ID_valid;
    logic [3:0] ID_rs1;
    logic [3:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic [3:0] ID_rd;
    logic       ID_wr_en;
    logic       ID_is_load;
    logic       EX_mispredict;
    logic       mem_req;
    logic       mem_ready;

    logic        a_pc_stall, a_if_id_stall, a_if_flush, a_id_ex_flush, a_mem_timeout, a_state;
    logic [15:0] a_stall_cycles, a_flush_count;
    logic        b_pc_stall, b_if_id_stall, b_if_flush, b_id_ex_flush, b_mem_timeout, b_state;
    logic [1:0]  b_stall_cycles, b_flush_count;

    int chk_cnt = 0;
    int err_cnt = 0;

    pipeline_hazard_controller #(
        .REG_W (4), .FORWARDING (1), .MAX_WAIT (15), .CNT_W (16)
    ) dut_a (
        .clk (clk), .rst (rst),
        .ID_valid (ID_valid), .ID_rs1 (ID_rs1), .ID_rs2 (ID_rs2),
        .ID_use_rs1 (ID_use_rs1), .ID_use_rs2 (ID_use_rs2),
        .ID_rd (ID_rd), .ID_wr_en (ID_wr_en), .ID_is_load (ID_is_load),
        .EX_mispredict (EX_mispredict), .mem_req (mem_req), .mem_ready (mem_ready),
        .PC_stall (a_pc_stall), .IF_ID_stall (a_if_id_stall), .IF_flush (a_if_flush),
        .ID_EX_flush (a_id_ex_flush), .mem_timeout (a_mem_timeout),
        .stall_cycles (a_stall_cycles), .flush_count (a_flush_count), .dbg_state (a_state)
    );

    pipeline_hazard_controller #(
        .REG_W (4), .FORWARDING (0), .MAX_WAIT (3), .CNT_W (2)
    ) dut_b (
        .clk (clk), .rst (rst),
        .ID_valid (ID_valid), .ID_rs1 (ID_rs1), .ID_rs2 (ID_rs2),
        .ID_use_rs1 (ID_use_rs1), .ID_use_rs2 (ID_use_rs2),
        .ID_rd (ID_rd), .ID_wr_en (ID_wr_en), .ID_is_load (ID_is_load),
        .EX_mispredict (EX_mispredict), .mem_req (mem_req), .mem_ready (mem_ready),
        .PC_stall (b_pc_stall), .IF_ID_stall (b_if_id_stall), .IF_flush (b_if_flush),
        .ID_EX_flush (b_id_ex_flush), .mem_timeout (b_mem_timeout),
        .stall_cycles (b_stall_cycles), .flush_count (b_flush_count), .dbg_state (b_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [3:0] rd, input logic wr, input logic ld,
                          input logic [3:0] rs1, input logic u1, input logic [3:0] rs2, input logic u2);
        ID_valid   = v;
        ID_rd      = rd;
        ID_wr_en   = wr;
        ID_is_load = ld;
        ID_rs1     = rs1;
        ID_use_rs1 = u1;
        ID_rs2     = rs2;
        ID_use_rs2 = u2;
    endtask

    task automatic nop();
        set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        nop();
        EX_mispredict = 1'b0;
        mem_req       = 1'b0;
        mem_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset: strobes held low even with a freeze request and hazard-shaped inputs present
        rst = 1'b1;
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1);
        EX_mispredict = 1'b1;
        mem_req       = 1'b1;
        mem_ready     = 1'b0;
        step();
        sample();
        check("rst_pc_stall", {31'd0, a_pc_stall}, 32'd0);
        check("rst_if_flush", {31'd0, a_if_flush}, 32'd0);
        check("rst_state", {31'd0, a_state}, 32'd0);
        check("rst_stall_cnt", {16'd0, a_stall_cycles}, 32'd0);
        check("rst_timeout", {31'd0, a_mem_timeout}, 32'd0);
        do_reset();

        // 1. LW R3 ; ADD R4,R3,R5 -> one stall cycle with forwarding
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        sample();
        check("t1_lw_no_stall", {31'd0, a_pc_stall}, 32'd0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1);
        sample();
        check("t1_pc_stall", {31'd0, a_pc_stall}, 32'd1);
        check("t1_if_id_stall", {31'd0, a_if_id_stall}, 32'd1);
        check("t1_id_ex_flush", {31'd0, a_id_ex_flush}, 32'd1);
        check("t1_if_flush", {31'd0, a_if_flush}, 32'd0);
        step();
        check("t1_stall_cnt", {16'd0, a_stall_cycles}, 32'd1);
        sample();
        check("t1_released", {31'd0, a_pc_stall}, 32'd0);
        check("t1_no_bubble", {31'd0, a_id_ex_flush}, 32'd0);
        step();
        nop();
        do_reset();

        // 2. ADD R3 ; SUB R6,R3,R1 -> none with forwarding, two stalls without
        set_id(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd1, 1'b1);
        sample();
        check("t2_fwd_no_stall", {31'd0, a_pc_stall}, 32'd0);
        check("t2_nofwd_stall_ex", {31'd0, b_pc_stall}, 32'd1);
        step();
        sample();
        check("t2_nofwd_stall_mem", {31'd0, b_pc_stall}, 32'd1);
        check("t2_nofwd_bubble", {31'd0, b_id_ex_flush}, 32'd1);
        step();
        check("t2_nofwd_cnt", {30'd0, b_stall_cycles}, 32'd2);
        check("t2_fwd_cnt", {16'd0, a_stall_cycles}, 32'd0);
        sample();
        check("t2_nofwd_proceed", {31'd0, b_pc_stall}, 32'd0);
        step();
        // Two more stalls on instance b: a 2-bit counter saturates at 3
        set_id(1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
        step();
        step();
        nop();
        step();
        check("t2_sat_cnt", {30'd0, b_stall_cycles}, 32'd3);
        check("t2_fwd_load_cnt", {16'd0, a_stall_cycles}, 32'd1);
        do_reset();

        // 3. LW R0 ; ADD R1,R0,R0 -> R0 never a hazard
        set_id(1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1);
        sample();
        check("t3_fwd_r0", {31'd0, a_pc_stall}, 32'd0);
        check("t3_nofwd_r0", {31'd0, b_pc_stall}, 32'd0);
        step();
        check("t3_cnt", {16'd0, a_stall_cycles}, 32'd0);
        nop();
        do_reset();

        // 4. LW R3 in EX, then a 4-cycle memory freeze with the dependent ADD waiting in ID
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1);
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t4_frz_pc_stall", {31'd0, a_pc_stall}, 32'd1);
            check("t4_frz_if_id", {31'd0, a_if_id_stall}, 32'd1);
            check("t4_frz_no_bubble", {31'd0, a_id_ex_flush}, 32'd0);
            check("t4_frz_state", {31'd0, a_state}, (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        mem_ready = 1'b1;
        sample();
        // EX still holds the load, so the ready cycle sees the load-use hazard
        check("t4_ready_hazard", {31'd0, a_id_ex_flush}, 32'd1);
        check("t4_ready_state", {31'd0, a_state}, 32'd1);
        step();
        check("t4_stall_cnt", {16'd0, a_stall_cycles}, 32'd1);
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        nop();
        sample();
        check("t4_back_idle", {31'd0, a_state}, 32'd0);
        do_reset();

        // 5. Mispredict coinciding with a load-use hazard, then a mispredict held through a freeze
        set_id(1'b1, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        set_id(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1);
        EX_mispredict = 1'b1;
        sample();
        check("t5_if_flush", {31'd0, a_if_flush}, 32'd1);
        check("t5_id_ex_flush", {31'd0, a_id_ex_flush}, 32'd1);
        check("t5_pc_stall", {31'd0, a_pc_stall}, 32'd0);
        check("t5_if_id_stall", {31'd0, a_if_id_stall}, 32'd0);
        step();
        check("t5_flush_cnt", {16'd0, a_flush_count}, 32'd1);
        check("t5_stall_cnt", {16'd0, a_stall_cycles}, 32'd0);
        nop();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        sample();
        check("t5_frz_if_flush", {31'd0, a_if_flush}, 32'd0);
        check("t5_frz_pc_stall", {31'd0, a_pc_stall}, 32'd1);
        step();
        mem_ready = 1'b1;
        sample();
        check("t5_unfrz_if_flush", {31'd0, a_if_flush}, 32'd1);
        step();
        check("t5_flush_cnt2", {16'd0, a_flush_count}, 32'd2);
        EX_mispredict = 1'b0;
        mem_req       = 1'b0;
        mem_ready     = 1'b0;
        do_reset();

        // 6. Long wait: cycle k sees k-1 edges; counter is 0 on entry, reaches 15 on edge 16
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            sample();
            check("t6_timeout", {31'd0, a_mem_timeout}, (k >= 17) ? 32'd1 : 32'd0);
            check("t6_frz", {31'd0, a_pc_stall}, 32'd1);
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_req   = 1'b0;
        sample();
        check("t6_sticky", {31'd0, a_mem_timeout}, 32'd1);
        check("t6_idle_after_ready", {31'd0, a_state}, 32'd0);
        mem_req = 1'b1;
        step();
        step();
        check("t6_rewait_state", {31'd0, a_state}, 32'd1);
        // Asynchronous reset between edges
        rst = 1'b1;
        #2;
        check("t6_rst_pc_stall", {31'd0, a_pc_stall}, 32'd0);
        check("t6_rst_if_id", {31'd0, a_if_id_stall}, 32'd0);
        check("t6_rst_timeout", {31'd0, a_mem_timeout}, 32'd0);
        check("t6_rst_state", {31'd0, a_state}, 32'd0);
        mem_req = 1'b0;
        step();
        rst = 1'b0;
        sample();
        check("t6_post_rst_state", {31'd0, a_state}, 32'd0);
        check("t6_post_rst_timeout", {31'd0, a_mem_timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
